adder_reduce_sched: RTL

Scheduler that reduces a stream of N_OPS fixed-point operands to one sum using a single shared pipelined FixedPointAdder, in place of a full adder tree. It accepts operands over a valid/ready stream and issues pairwise adds to the external adder. It recirculates partial sums through one holding register and reports the final sum with a one-cycle valid pulse. It sits between the operand source and one FixedPointAdder instance in the accumulation datapath.

---
 rtl/adder_reduce_sched_pkg.sv | 22 ++
 rtl/adder_reduce_sched_if.sv | 36 +++
 rtl/adder_reduce_sched_retire_pipe.sv | 64 ++++++
 rtl/adder_reduce_sched.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/adder_reduce_sched_pkg.sv
// adder_sched_pkg: shared state encoding, default width and counter sizing for adder_reduce_sched.
// Revision: 1.0
`default_nettype none

package adder_sched_pkg;

    localparam int WIDTH_DEF = 26;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Counters must be able to hold N_OPS itself, not just N_OPS-1.
    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/adder_reduce_sched_if.sv
// adder_reduce_sched_if: operand stream, shared-adder port and result signals of adder_reduce_sched.
// Revision: 1.0
`default_nettype none

interface adder_reduce_sched_if
    import adder_sched_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) ();

    logic             start;
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] add_a;
    logic [WIDTH-1:0] add_b;
    logic             add_issue;
    logic [WIDTH-1:0] add_res;
    logic [WIDTH-1:0] sum_out;
    logic             sum_valid;
    logic             busy;
    logic             ovf;

    modport master (
        input  start, in_data, in_valid, add_res,
        output in_ready, add_a, add_b, add_issue, sum_out, sum_valid, busy, ovf
    );

    modport slave (
        output start, in_data, in_valid, add_res,
        input  in_ready, add_a, add_b, add_issue, sum_out, sum_valid, busy, ovf
    );

endinterface

`default_nettype wire

// File: rtl/adder_reduce_sched_retire_pipe.sv
// add_retire_pipe: RET_LAT-deep valid shift register tracking adds in flight in the shared adder.
// With ADDER_SCHED_OVF_EN defined it also delays the two operand sign bits. Revision: 1.0
`default_nettype none

module add_retire_pipe #(
    parameter int RET_LAT = 1
) (
    input  wire logic clk,
    input  wire logic i_rst_n,
    input  wire logic i_push,
`ifdef ADDER_SCHED_OVF_EN
    input  wire logic i_sign_a,
    input  wire logic i_sign_b,
    output logic      o_sign_a,
    output logic      o_sign_b,
`endif
    output logic      o_pop,
    output logic      o_pending
);

`ifdef ADDER_SCHED_OVF_EN
    localparam int C_SW = 3;
    logic [C_SW-1:0] w_stage_in;
    assign w_stage_in = {i_push, i_sign_a, i_sign_b};
`else
    localparam int C_SW = 1;
    logic [C_SW-1:0] w_stage_in;
    assign w_stage_in = i_push;
`endif

    logic [C_SW-1:0] r_stage [RET_LAT];

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < RET_LAT; i++) r_stage[i] <= '0;
        end else begin
            r_stage[0] <= w_stage_in;
            for (int i = 1; i < RET_LAT; i++) r_stage[i] <= r_stage[i-1];
        end
    end

    // Pending = adds still travelling that do not retire this cycle.
    generate
        if (RET_LAT == 1) begin : g_single
            assign o_pending = 1'b0;
        end else begin : g_deep
            logic [RET_LAT-2:0] w_vld;
            for (genvar g = 0; g < RET_LAT - 1; g++) begin : g_vld
                assign w_vld[g] = r_stage[g][C_SW-1];
            end
            assign o_pending = |w_vld;
        end
    endgenerate

    assign o_pop = r_stage[RET_LAT-1][C_SW-1];

`ifdef ADDER_SCHED_OVF_EN
    assign o_sign_a = r_stage[RET_LAT-1][1];
    assign o_sign_b = r_stage[RET_LAT-1][0];
`endif

endmodule

`default_nettype wire

// File: rtl/adder_reduce_sched.sv
// adder_reduce_sched: reduces N_OPS streamed operands to one sum through a single shared pipelined adder.
// Optional sticky overflow detection under macro ADDER_SCHED_OVF_EN. Revision: 1.0
`default_nettype none

module adder_reduce_sched
    import adder_sched_pkg::*;
#(
    parameter int WIDTH   = WIDTH_DEF,
    parameter int N_OPS   = 98,
    parameter int RET_LAT = 1
) (
    input  wire logic            clk,
    input  wire logic            GlobalReset,
    adder_reduce_sched_if.master bus
);

    localparam int            C_CW       = cnt_width(N_OPS);
    localparam logic [C_CW-1:0] C_N_OPS    = C_CW'(N_OPS);
    localparam logic [C_CW-1:0] C_LAST_ADD = C_CW'(N_OPS - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [WIDTH-1:0]  r_h;
    logic              r_h_vld;
    logic [WIDTH-1:0]  r_add_a;
    logic [WIDTH-1:0]  r_add_b;
    logic              r_add_issue;
    logic [WIDTH-1:0]  r_sum;
    logic [C_CW-1:0]   r_acc;
    logic [C_CW-1:0]   r_adds;

    logic              w_accum;
    logic              w_in_ready;
    logic              w_take;
    logic              w_start_ok;
    logic              w_pop;
    logic              w_pending;
    logic              w_do_add;
    logic              w_final;
    logic [WIDTH-1:0]  w_a;
    logic [WIDTH-1:0]  w_b;
    logic [WIDTH-1:0]  w_h_nxt;
    logic              w_h_vld_nxt;

    assign w_accum    = (r_state == ACCUM);
    assign w_in_ready = w_accum && (r_acc != C_N_OPS);
    assign w_take     = w_in_ready && bus.in_valid;
    assign w_start_ok = (r_state == IDLE) && bus.start;

`ifdef ADDER_SCHED_OVF_EN
    logic w_sign_a;
    logic w_sign_b;
`endif

    add_retire_pipe #(
        .RET_LAT (RET_LAT)
    ) u_retire (
        .clk       (clk),
        .i_rst_n   (GlobalReset),
        .i_push    (r_add_issue),
`ifdef ADDER_SCHED_OVF_EN
        .i_sign_a  (r_add_a[WIDTH-1]),
        .i_sign_b  (r_add_b[WIDTH-1]),
        .o_sign_a  (w_sign_a),
        .o_sign_b  (w_sign_b),
`endif
        .o_pop     (w_pop),
        .o_pending (w_pending)
    );

    // Pair priority R+H, R+I, H+I; a lone or leftover candidate parks in H.
    always_comb begin
        w_do_add    = 1'b0;
        w_a         = bus.add_res;
        w_b         = r_h;
        w_h_nxt     = r_h;
        w_h_vld_nxt = r_h_vld;
        if (w_accum) begin
            if (w_pop && r_h_vld) begin
                w_do_add    = 1'b1;
                w_a         = bus.add_res;
                w_b         = r_h;
                w_h_nxt     = bus.in_data;
                w_h_vld_nxt = w_take;
            end else if (w_pop && w_take) begin
                w_do_add    = 1'b1;
                w_a         = bus.add_res;
                w_b         = bus.in_data;
                w_h_vld_nxt = 1'b0;
            end else if (r_h_vld && w_take) begin
                w_do_add    = 1'b1;
                w_a         = r_h;
                w_b         = bus.in_data;
                w_h_vld_nxt = 1'b0;
            end else if (w_pop) begin
                w_h_nxt     = bus.add_res;
                w_h_vld_nxt = 1'b1;
            end else if (w_take) begin
                w_h_nxt     = bus.in_data;
                w_h_vld_nxt = 1'b1;
            end
        end
    end

    // Once N_OPS-1 adds are decided, a quiet pipe leaves exactly one value: the sum.
    assign w_final = w_accum && (r_adds == C_LAST_ADD) && !w_do_add && !r_add_issue
                     && !w_pending && w_h_vld_nxt;

    always_ff @(posedge clk or negedge GlobalReset) begin
        if (!GlobalReset) r_state <= IDLE;
        else              r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (bus.start) w_state_nxt = ACCUM;
            ACCUM:   if (w_final)   w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge GlobalReset) begin
        if (!GlobalReset) begin
            r_h         <= '0;
            r_h_vld     <= 1'b0;
            r_add_a     <= '0;
            r_add_b     <= '0;
            r_add_issue <= 1'b0;
            r_sum       <= '0;
            r_acc       <= '0;
            r_adds      <= '0;
        end else begin
            r_add_issue <= w_do_add;
            if (w_do_add) begin
                r_add_a <= w_a;
                r_add_b <= w_b;
            end
            if (w_start_ok) begin
                r_acc   <= '0;
                r_adds  <= '0;
                r_h_vld <= 1'b0;
            end else begin
                if (w_take)   r_acc  <= r_acc + C_CW'(1);
                if (w_do_add) r_adds <= r_adds + C_CW'(1);
                r_h     <= w_h_nxt;
                r_h_vld <= w_h_vld_nxt;
            end
            if (w_final) r_sum <= w_h_nxt;
        end
    end

`ifdef ADDER_SCHED_OVF_EN
    logic r_ovf;

    always_ff @(posedge clk or negedge GlobalReset) begin
        if (!GlobalReset) begin
            r_ovf <= 1'b0;
        end else if (w_start_ok) begin
            r_ovf <= 1'b0;
        end else if (w_pop && (w_sign_a == w_sign_b) && (w_sign_a != bus.add_res[WIDTH-1])) begin
            r_ovf <= 1'b1;
        end
    end

    assign bus.ovf = r_ovf;
`else
    assign bus.ovf = 1'b0;
`endif

    assign bus.in_ready  = w_in_ready;
    assign bus.add_a     = r_add_a;
    assign bus.add_b     = r_add_b;
    assign bus.add_issue = r_add_issue;
    assign bus.sum_out   = r_sum;
    assign bus.sum_valid = (r_state == DONE);
    assign bus.busy      = (r_state != IDLE);

endmodule

`default_nettype wire
